soft_clip_multi: RTL and testbench

SOFT_CLIP_MULTI -- requirements
Module: soft_clip_multi

---
 rtl/soft_clip_multi.sv | 165 ++++++++++++++++
 tb/tb_soft_clip_multi.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/soft_clip_multi.sv
// Multi-channel soft clipper: one shared knee/compression datapath walks the channels of a frame.
// Optional per-channel clip-event counters are built when SOFT_CLIP_COUNT_EN is defined.
module soft_clip_multi #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int COMP_BITS = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH*CHANNELS-1:0]     in_data,
  input  logic [COMP_BITS-1:0]          comp_in,
  input  logic [1:0]                    ratio,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*CHANNELS-1:0]     out_data,
  output logic [CNT_WIDTH*CHANNELS-1:0] clip_count
);

  localparam int IDX_W = $clog2(CHANNELS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [WIDTH*CHANNELS-1:0]   frame_q, frame_d;
  logic [COMP_BITS-1:0]        comp_q, comp_d;
  logic [1:0]                  ratio_q, ratio_d;
  logic [WIDTH-1:0]            sample_q, sample_d;
  logic [WIDTH*CHANNELS-1:0]   out_q, out_d;
  logic [WIDTH-1:0]            sample_sel;
  logic [CHANNELS-1:0]         wr_en;

  logic signed [WIDTH-1:0]     x_s, t_s, neg_t_s, diff_lo_s, y_s;
  logic [WIDTH-1:0]            diff_hi;
  logic [2:0]                  s_amt;
  logic                        clip_hi, clip_lo;

  // Two-stage walk: at index i the operand register loads channel i while the
  // result for channel i-1 is written back, so PROC spans CHANNELS+1 cycles.
  always_comb begin
    sample_sel = '0;
    wr_en      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sample_sel = frame_q[i*WIDTH +: WIDTH];
      end
      wr_en[i] = (state_q == PROC) && (idx_q == IDX_W'(i + 1));
    end
  end

  always_comb begin
    s_amt     = {1'b0, ratio_q} + 3'd1;
    t_s       = $signed(WIDTH'(comp_q) << (WIDTH - 1 - COMP_BITS));
    neg_t_s   = -t_s;
    x_s       = $signed(sample_q);
    clip_hi   = (x_s >= t_s);
    clip_lo   = (x_s < neg_t_s);
    diff_hi   = $unsigned(x_s - t_s);
    diff_lo_s = x_s + t_s;
    y_s       = x_s;
    if (clip_hi) begin
      y_s = t_s + $signed(diff_hi >> s_amt);
    end else if (clip_lo) begin
      y_s = neg_t_s + (diff_lo_s >>> s_amt);
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    comp_d   = comp_q;
    ratio_d  = ratio_q;
    sample_d = sample_q;
    out_d    = out_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en[i]) begin
        out_d[i*WIDTH +: WIDTH] = $unsigned(y_s);
      end
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frame_d = in_data;
          comp_d  = comp_in;
          ratio_d = ratio;
          idx_d   = '0;
          state_d = PROC;
        end
      end
      PROC: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q != LAST) begin
          sample_d = sample_sel;
        end else begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      frame_q  <= '0;
      comp_q   <= '0;
      ratio_q  <= '0;
      sample_q <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      comp_q   <= comp_d;
      ratio_q  <= ratio_d;
      sample_q <= sample_d;
      out_q    <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

`ifdef SOFT_CLIP_COUNT_EN
  logic clip_hit;
  assign clip_hit = clip_hi | clip_lo;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (wr_en[gi] && clip_hit && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign clip_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_soft_clip_multi.sv
// Scoreboard bench for soft_clip_multi (WIDTH=16, CHANNELS=2, COMP_BITS=4, CNT_WIDTH=8).
// Expected counters follow SOFT_CLIP_COUNT_EN the same way the design does.
module tb_soft_clip_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  comp_in;
  logic [1:0]  ratio;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] clip_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];
  int cnt_model[2];

  soft_clip_multi #(.WIDTH(16), .CHANNELS(2), .COMP_BITS(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .comp_in(comp_in), .ratio(ratio), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x, input logic [3:0] c, input logic [1:0] r);
    int xi, t, s, v, q;
    xi = int'($signed(x));
    t  = int'(c) * 2048;
    s  = 1 << (int'(r) + 1);
    if (xi >= t) q = t + (xi - t) / s;
    else if (xi < -t) begin
      v = xi + t;
      q = -t + (v - (s - 1)) / s;  // floor division for negative v
    end else q = xi;
    return q[15:0];
  endfunction

  function automatic bit is_clip(input logic [15:0] x, input logic [3:0] c);
    int xi, t;
    xi = int'($signed(x));
    t  = int'(c) * 2048;
    return (xi >= t) || (xi < -t);
  endfunction

  function automatic logic [15:0] exp_counts();
    logic [15:0] r;
    r = '0;
`ifdef SOFT_CLIP_COUNT_EN
    r = {cnt_model[1][7:0], cnt_model[0][7:0]};
`endif
    return r;
  endfunction

  task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1, input logic [3:0] c,
                           input logic [1:0] r, input int hold);
    logic [31:0] exp;
    int lat;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = {d1, d0};
    comp_in   = c;
    ratio     = r;
    out_ready = 1'b0;
    sb.push_back({model(d1, c, r), model(d0, c, r)});
    if (is_clip(d0, c) && cnt_model[0] < 255) cnt_model[0]++;
    if (is_clip(d1, c) && cnt_model[1] < 255) cnt_model[1]++;
    @(posedge clk); #1;
    // Garbage on every input mid-frame must not disturb the captured frame.
    in_data = $urandom;
    comp_in = 4'($urandom);
    ratio   = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("out_data", out_data, exp);
    check("clip_count", {16'd0, clip_count}, {16'd0, exp_counts()});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_data", out_data, exp);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    $display("frame in=%h comp=%0d ratio=%0d out=%h exp=%h cnt=%h", {d1, d0}, c, r, out_data, exp, clip_count);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; comp_in = '0; ratio = '0; out_ready = 1'b0;
    cnt_model[0] = 0; cnt_model[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_clip_count", {16'd0, clip_count}, 32'd0);

    run_frame(16'h6000, 16'hA000, 4'd4, 2'd0, 0);
    run_frame(16'h7FFF, 16'h1FFF, 4'd4, 2'd3, 0);
    run_frame(16'h0002, 16'hFFFE, 4'd0, 2'd0, 0);
    run_frame(16'h7000, 16'h8000, 4'd4, 2'd1, 5);
    run_frame(16'hE000, 16'h2000, 4'd4, 2'd2, 0);
    run_frame(16'h8000, 16'h7FFF, 4'd15, 2'd3, 0);
    for (int i = 0; i < 6; i++)
      run_frame(16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom), 1);

    // Reset mid-frame discards the frame.
    in_valid = 1'b1; in_data = 32'h1234_7000; comp_in = 4'd4; ratio = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_model[0] = 0; cnt_model[1] = 0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_clip_count", {16'd0, clip_count}, 32'd0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("midrst_no_output", 32'(n), 32'd0);

    // Counter saturation: ch0 clips every frame, ch1 never does.
    for (int i = 0; i < 300; i++)
      run_frame(16'h7000, 16'h0100, 4'd4, 2'd0, 0);
    check("sat_count", {16'd0, clip_count}, {16'd0, exp_counts()});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
